// File: rtl/fp_mult_pkg.sv
// Shared definitions for the sequential floating-point multiplier:
// FSM encoding, rounding-mode constants and exponent-format helpers.
package fp_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int calc_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_mant_seq_mul.sv
// Unsigned shift-add multiplier. It retires one multiplier bit per cycle,
// and the 2M-bit product is complete M cycles after start.
module fp_mant_seq_mul #(
  parameter int M = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   x,
  input  logic [M-1:0]   y,
  output logic           done,
  output logic [2*M-1:0] prod
);

  localparam int CW = $clog2(M + 1);

  logic [2*M-1:0] acc;
  logic [2*M-1:0] mcand;
  logic [M-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{M{1'b0}}, x};
      mplier <= y;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(M - 1)) busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final step.
  assign done = busy && (cnt == CW'(M - 1));
  assign prod = acc;

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754-style multiplier with an iterative mantissa engine,
// truncate or round-to-nearest-even rounding, and overflow/underflow flags.
module fp_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  input  logic                    rnd_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [EXP_W+FRAC_W:0]   product,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int M    = FRAC_W + 1;
  localparam int BIAS = calc_bias(EXP_W);
  localparam int EMAX = calc_emax(EXP_W);
  localparam int EW   = EXP_W + 2;

  localparam logic [EXP_W-1:0]    EXP_ONES = {EXP_W{1'b1}};
  localparam logic signed [EW-1:0] EMAX_S  = EW'(EMAX);
  localparam logic signed [EW-1:0] ZERO_S  = '0;

  state_t state, state_n;

  logic             sign_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  logic             rnd_r;

  logic             accept;
  logic             mul_done;
  logic [2*M-1:0]   mprod;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The input side is ready only in IDLE; the result is held until taken.
  assign in_ready  = (state == IDLE) && rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  fp_mant_seq_mul #(.M(M)) u_mant (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .x     ({1'b1, a[FRAC_W-1:0]}),
    .y     ({1'b1, b[FRAC_W-1:0]}),
    .done  (mul_done),
    .prod  (mprod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = MUL;
      MUL:     if (mul_done) state_n = NORM;
      NORM:    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic                    msb;
  logic [2*M-2:0]          pn;
  logic [FRAC_W-1:0]       frac_t;
  logic                    guard, sticky, rnd_up;
  logic [FRAC_W:0]         frac_rnd;
  logic [EW-1:0]           exp_sum;
  logic signed [EW-1:0]    exp_fin;
  logic [W-1:0]            res_p;
  logic                    res_ov, res_un;

  // Normalise so the hidden one sits just above the kept fraction.
  always_comb begin
    msb      = mprod[2*M-1];
    pn       = msb ? mprod[2*M-2:0] : {mprod[2*M-3:0], 1'b0};
    frac_t   = pn[2*M-2 -: FRAC_W];
    guard    = pn[M-1];
    sticky   = |pn[M-2:0];
    rnd_up   = (rnd_r == RND_RNE) && guard && (sticky || frac_t[0]);
    frac_rnd = {1'b0, frac_t} + {{FRAC_W{1'b0}}, rnd_up};
    exp_sum  = {2'b00, ea_r} + {2'b00, eb_r} - EW'(BIAS) + {{(EW-1){1'b0}}, msb};
    exp_fin  = $signed(exp_sum + {{(EW-1){1'b0}}, frac_rnd[FRAC_W]});

    // A rounding carry leaves the low FRAC_W bits of frac_rnd at zero.
    res_p  = {sign_r, exp_fin[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
    res_ov = 1'b0;
    res_un = 1'b0;
    if (ea_r == EXP_ONES || eb_r == EXP_ONES) begin
      res_p  = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
      res_ov = 1'b1;
    end else if (ea_r == '0 || eb_r == '0) begin
      res_p = '0;
    end else if (exp_fin >= EMAX_S) begin
      res_p  = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
      res_ov = 1'b1;
    end else if (exp_fin <= ZERO_S) begin
      res_p  = {sign_r, {(W-1){1'b0}}};
      res_un = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_r    <= 1'b0;
      ea_r      <= '0;
      eb_r      <= '0;
      rnd_r     <= 1'b0;
      product   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (accept) begin
        sign_r <= a[W-1] ^ b[W-1];
        ea_r   <= a[W-2:FRAC_W];
        eb_r   <= b[W-2:FRAC_W];
        rnd_r  <= rnd_mode;
      end
      if (state == NORM) begin
        product   <= res_p;
        overflow  <= res_ov;
        underflow <= res_un;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: default and half-precision instances, directed
// cases plus randomized operands checked against an arithmetic model.
module tb_fp_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a = '0, b = '0, product;
  logic        rnd_mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, overflow, underflow, out_valid;

  logic [15:0] h_a = '0, h_b = '0, h_product;
  logic        h_rnd_mode = 1'b0, h_in_valid = 1'b0, h_out_ready = 1'b0;
  logic        h_in_ready, h_overflow, h_underflow, h_out_valid;

  fp_mult_seq dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .rnd_mode(rnd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .product(product),
    .overflow(overflow), .underflow(underflow), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  fp_mult_seq #(.EXP_W(5), .FRAC_W(10)) dut_h (
    .clk(clk), .rst(rst), .a(h_a), .b(h_b), .rnd_mode(h_rnd_mode),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .product(h_product),
    .overflow(h_overflow), .underflow(h_underflow), .out_valid(h_out_valid),
    .out_ready(h_out_ready)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [33:0] exp_q[$];
  bit sel = 1'b0;

  wire [31:0] s_product   = sel ? {16'h0, h_product} : product;
  wire        s_ov        = sel ? h_overflow  : overflow;
  wire        s_un        = sel ? h_underflow : underflow;
  wire        s_out_valid = sel ? h_out_valid : out_valid;
  wire        s_in_ready  = sel ? h_in_ready  : in_ready;
  wire [33:0] s_result    = {s_ov, s_un, s_product};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer mantissa product, then divide-and-compare rounding.
  function automatic logic [33:0] model(input int ew, input int fw,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input bit rnd);
    longint unsigned ma, mb, prod, q, rem, half;
    int emax, bias, e, shift, ex, ey;
    logic [31:0] p, s;
    bit ov, un;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    s    = 32'(x[ew+fw] ^ y[ew+fw]);
    ex   = int'((x >> fw) & 32'(emax));
    ey   = int'((y >> fw) & 32'(emax));
    ov = 1'b0; un = 1'b0; p = '0;
    if (ex == emax || ey == emax) begin
      p  = (s << (ew + fw)) | (32'(emax) << fw);
      ov = 1'b1;
    end else if (ex == 0 || ey == 0) begin
      p = '0;
    end else begin
      ma    = 64'(x & ((32'd1 << fw) - 1)) + (64'd1 << fw);
      mb    = 64'(y & ((32'd1 << fw) - 1)) + (64'd1 << fw);
      prod  = ma * mb;
      e     = ex + ey - bias;
      shift = fw;
      if (prod >= (64'd1 << (2 * fw + 1))) begin
        e++;
        shift = fw + 1;
      end
      q    = prod >> shift;
      rem  = prod - (q << shift);
      half = 64'd1 << (shift - 1);
      if (rnd && (rem > half || (rem == half && q[0]))) q++;
      if (q == (64'd1 << (fw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= emax) begin
        p  = (s << (ew + fw)) | (32'(emax) << fw);
        ov = 1'b1;
      end else if (e <= 0) begin
        p  = s << (ew + fw);
        un = 1'b1;
      end else begin
        p = (s << (ew + fw)) | (32'(e) << fw) | 32'(q - (64'd1 << fw));
      end
    end
    return {ov, un, p};
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int fw);
    int emax, bias, e;
    logic [31:0] f;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    if ($urandom_range(0, 9) == 0) e = ($urandom_range(0, 1) == 1) ? 0 : emax;
    else if ($urandom_range(0, 1) == 1) e = int'($urandom_range(0, emax));
    else e = bias - 6 + int'($urandom_range(0, 12));
    f = $urandom & ((32'd1 << fw) - 1);
    return (32'($urandom_range(0, 1)) << (ew + fw)) | (32'(e) << fw) | f;
  endfunction

  task automatic drive_in(input logic [31:0] x, input logic [31:0] y, input bit r, input bit v);
    if (sel) begin
      h_a = x[15:0]; h_b = y[15:0]; h_rnd_mode = r; h_in_valid = v;
    end else begin
      a = x; b = y; rnd_mode = r; in_valid = v;
    end
  endtask

  task automatic set_out_ready(input bit v);
    if (sel) h_out_ready = v;
    else     out_ready   = v;
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input bit r);
    int tries;
    tries = 0;
    @(negedge clk);
    drive_in(x, y, r, 1'b1);
    while (!s_in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!s_in_ready) check("accept_timeout", 64'(s_in_ready), 64'd1);
    @(posedge clk);
    #1 drive_in(x, y, r, 1'b0);
    exp_q.push_back(model(sel ? 5 : 8, sel ? 10 : 23, x, y, r));
  endtask

  task automatic wait_result(input string tag);
    int edges;
    bit busy_ready;
    edges = 0;
    busy_ready = 1'b0;
    while (!s_out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (s_in_ready) busy_ready = 1'b1;
    end
    check({tag, "_latency"}, 64'(edges), sel ? 64'd12 : 64'd25);
    check({tag, "_in_ready_busy"}, 64'(busy_ready), 64'd0);
  endtask

  task automatic finish_op(input string tag, input int hold, input bit pulse,
                           output logic [33:0] got);
    logic [33:0] exp;
    got = s_result;
    for (int i = 0; i < hold; i++) begin
      if (pulse) drive_in($urandom, $urandom, 1'b0, (i % 2) == 0);
      @(posedge clk);
      #1;
      check({tag, "_hold"}, 64'({s_out_valid, s_result}), 64'({1'b1, got}));
    end
    drive_in('0, '0, 1'b0, 1'b0);
    set_out_ready(1'b1);
    @(posedge clk);
    #1 set_out_ready(1'b0);
    check({tag, "_ready_after"}, 64'(s_in_ready), 64'd1);
    check({tag, "_valid_cleared"}, 64'(s_out_valid), 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_no_expect"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 64'(got), 64'(exp));
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input bit r, input int hold, output logic [33:0] got);
    start_op(x, y, r);
    wait_result(tag);
    finish_op(tag, hold, 1'b0, got);
  endtask

  initial begin
    logic [33:0] got;
    logic [31:0] x, y;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({product, overflow, underflow, out_valid, in_ready}), 64'd0);
    check("reset_outputs_h", 64'({h_product, h_overflow, h_underflow, h_out_valid, h_in_ready}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'({in_ready, h_in_ready}), 64'd3);

    sel = 1'b0;
    run_op("basic", 32'h408a2000, 32'hc08a2000, 1'b0, 0, got);
    check("basic_const", 64'(got), 64'({2'b00, 32'hc1950d08}));
    run_op("trunc", 32'h3fc00001, 32'h3fc00001, 1'b0, 0, got);
    check("trunc_const", 64'(got), 64'({2'b00, 32'h40100001}));
    run_op("rne", 32'h3fc00001, 32'h3fc00001, 1'b1, 0, got);
    check("rne_const", 64'(got), 64'({2'b00, 32'h40100002}));
    run_op("zero", 32'h00000000, 32'h418aa000, 1'b0, 0, got);
    check("zero_const", 64'(got), 64'({2'b00, 32'h00000000}));
    run_op("ovf", 32'h7f000000, 32'h7f000000, 1'b0, 0, got);
    check("ovf_const", 64'(got), 64'({2'b10, 32'h7f800000}));
    run_op("unf", 32'h00800000, 32'h00800000, 1'b0, 0, got);
    check("unf_const", 64'(got), 64'({2'b01, 32'h00000000}));

    // Backpressure with ignored in_valid pulses while the result waits.
    start_op(32'h3f800000, 32'h418aa000, 1'b0);
    wait_result("bp");
    finish_op("bp", 10, 1'b1, got);
    check("bp_const", 64'(got), 64'({2'b00, 32'h418aa000}));
    @(posedge clk);
    #1;
    check("bp_no_spurious", 64'({s_out_valid, s_in_ready}), 64'({1'b0, 1'b1}));

    // Reset in the middle of the mantissa iteration.
    start_op(32'h40400000, 32'h40400000, 1'b0);
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midreset_outputs", 64'({product, overflow, underflow, out_valid, in_ready}), 64'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_no_output", 64'(out_valid), 64'd0);
    run_op("after_reset", 32'hc28aa000, 32'h418aa000, 1'b0, 0, got);
    check("after_reset_const", 64'(got), 64'({2'b00, 32'hc49621c8}));

    sel = 1'b1;
    run_op("h_one", 32'h3c00, 32'h4000, 1'b0, 0, got);
    check("h_one_const", 64'(got), 64'({2'b00, 32'h4000}));
    run_op("h_ovf", 32'h7800, 32'h7800, 1'b0, 0, got);
    check("h_ovf_const", 64'(got), 64'({2'b10, 32'h7c00}));

    for (int i = 0; i < 80; i++) begin
      sel = (i >= 45);
      x = rand_op(sel ? 5 : 8, sel ? 10 : 23);
      y = rand_op(sel ? 5 : 8, sel ? 10 : 23);
      start_op(x, y, $urandom_range(0, 1) == 1);
      wait_result("rand");
      finish_op("rand", int'($urandom_range(0, 3)), 1'b0, got);
      check("rand_flags_exclusive", 64'(got[33] && got[32]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
